// File: rtl/csr_regfile_pkg.sv
// Shared control definitions: CSR addresses, mstatus bit positions and CSR ALU op encodings.
package csr_regfile_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH= 12'hB82;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    function automatic logic csr_implemented(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Address bits [11:10]=2'b11 mark the read-only CSR space.
    function automatic logic csr_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// Decode/writeback/trap signalling between the pipeline (master) and the CSR file (slave).
interface csr_regfile_if #(
    parameter int WIDTH = 32
);
    logic [11:0]      csr_raddr_i;
    logic             csr_wr_intent_i;
    logic [WIDTH-1:0] csr_rdata_o;
    logic             csr_illegal_o;
    logic             csr_we_i;
    logic [11:0]      csr_waddr_i;
    logic [WIDTH-1:0] csr_wdata_i;
    logic             retire_i;
    logic             trap_i;
    logic [WIDTH-1:0] trap_cause_i;
    logic [WIDTH-1:0] trap_pc_i;
    logic             mret_i;
    logic [WIDTH-1:0] mtvec_o;
    logic [WIDTH-1:0] mepc_o;
    logic             mie_o;

    modport master (
        output csr_raddr_i, csr_wr_intent_i, csr_we_i, csr_waddr_i, csr_wdata_i,
               retire_i, trap_i, trap_cause_i, trap_pc_i, mret_i,
        input  csr_rdata_o, csr_illegal_o, mtvec_o, mepc_o, mie_o
    );

    modport slave (
        input  csr_raddr_i, csr_wr_intent_i, csr_we_i, csr_waddr_i, csr_wdata_i,
               retire_i, trap_i, trap_cause_i, trap_pc_i, mret_i,
        output csr_rdata_o, csr_illegal_o, mtvec_o, mepc_o, mie_o
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit event counter with independent 32-bit half loads; a load takes precedence over the increment.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        i_inc,
    input  logic        i_ld_lo,
    input  logic        i_ld_hi,
    input  logic [31:0] i_ld_data,
    output logic [63:0] o_value
);
    logic [63:0] r_value;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_value <= '0;
        end else if (i_ld_lo || i_ld_hi) begin
            if (i_ld_lo) r_value[31:0]  <= i_ld_data;
            if (i_ld_hi) r_value[63:32] <= i_ld_data;
        end else if (i_inc) begin
            r_value <= r_value + 64'd1;
        end
    end

    assign o_value = r_value;
endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: combinational decode-stage read, writeback-stage write, trap/mret sequencing.
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    csr_regfile_if.slave  bus
);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    logic [WIDTH-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause;
    logic             r_mie, r_mpie;
    logic [63:0]      w_mcycle, w_minstret;
    logic [WIDTH-1:0] w_rdata;
    logic             w_wr_ok, w_evt;
    logic             w_ld_cyc_lo, w_ld_cyc_hi, w_ld_ins_lo, w_ld_ins_hi;

    assign w_wr_ok = bus.csr_we_i && csr_implemented(bus.csr_waddr_i)
                     && !csr_read_only(bus.csr_waddr_i);
    assign w_evt   = bus.trap_i || bus.mret_i;

    assign w_ld_cyc_lo = w_wr_ok && (bus.csr_waddr_i == CSR_MCYCLE);
    assign w_ld_cyc_hi = w_wr_ok && (bus.csr_waddr_i == CSR_MCYCLEH);
    assign w_ld_ins_lo = w_wr_ok && (bus.csr_waddr_i == CSR_MINSTRET);
    assign w_ld_ins_hi = w_wr_ok && (bus.csr_waddr_i == CSR_MINSTRETH);

    csr_counter64 u_mcycle (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .i_inc     (1'b1),
        .i_ld_lo   (w_ld_cyc_lo),
        .i_ld_hi   (w_ld_cyc_hi),
        .i_ld_data (bus.csr_wdata_i[31:0]),
        .o_value   (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .i_inc     (bus.retire_i),
        .i_ld_lo   (w_ld_ins_lo),
        .i_ld_hi   (w_ld_ins_hi),
        .i_ld_data (bus.csr_wdata_i[31:0]),
        .o_value   (w_minstret)
    );

    // Trap/mret own mstatus, mepc and mcause in their cycle; a coincident CSR write to those is lost.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                case (bus.csr_waddr_i)
                    CSR_MTVEC:    r_mtvec    <= bus.csr_wdata_i & ALIGN_MASK;
                    CSR_MSCRATCH: r_mscratch <= bus.csr_wdata_i;
                    CSR_MEPC:     if (!w_evt) r_mepc   <= bus.csr_wdata_i & ALIGN_MASK;
                    CSR_MCAUSE:   if (!w_evt) r_mcause <= bus.csr_wdata_i;
                    CSR_MSTATUS: if (!w_evt) begin
                        r_mie  <= bus.csr_wdata_i[MSTATUS_MIE];
                        r_mpie <= bus.csr_wdata_i[MSTATUS_MPIE];
                    end
                    default: ;
                endcase
            end
            if (bus.trap_i) begin
                r_mepc   <= bus.trap_pc_i & ALIGN_MASK;
                r_mcause <= bus.trap_cause_i;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (bus.mret_i) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.csr_raddr_i)
            CSR_MSTATUS: begin
                w_rdata[MSTATUS_MIE]  = r_mie;
                w_rdata[MSTATUS_MPIE] = r_mpie;
            end
            CSR_MTVEC:                   w_rdata = r_mtvec;
            CSR_MSCRATCH:                w_rdata = r_mscratch;
            CSR_MEPC:                    w_rdata = r_mepc;
            CSR_MCAUSE:                  w_rdata = r_mcause;
            CSR_MCYCLE,    CSR_CYCLE:    w_rdata = WIDTH'(w_mcycle[31:0]);
            CSR_MCYCLEH,   CSR_CYCLEH:   w_rdata = WIDTH'(w_mcycle[63:32]);
            CSR_MINSTRET,  CSR_INSTRET:  w_rdata = WIDTH'(w_minstret[31:0]);
            CSR_MINSTRETH, CSR_INSTRETH: w_rdata = WIDTH'(w_minstret[63:32]);
            default: ;
        endcase
    end

    assign bus.csr_rdata_o   = w_rdata;
    assign bus.csr_illegal_o = !csr_implemented(bus.csr_raddr_i)
                               || (bus.csr_wr_intent_i && csr_read_only(bus.csr_raddr_i));
    assign bus.mtvec_o       = r_mtvec;
    assign bus.mepc_o        = r_mepc;
    assign bus.mie_o         = r_mie;
endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: counters, trap/mret sequencing, illegal decode and reset.
module tb_csr_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    csr_regfile_if #(.WIDTH(32)) bus ();

    csr_regfile #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        bus.csr_raddr_i = a;
        #1;
        d = bus.csr_rdata_o;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.csr_we_i    = 1'b1;
        bus.csr_waddr_i = a;
        bus.csr_wdata_i = d;
        tick();
        bus.csr_we_i    = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        bus.csr_raddr_i     = 12'h300;
        bus.csr_wr_intent_i = 1'b0;
        bus.csr_we_i        = 1'b0;
        bus.csr_waddr_i     = '0;
        bus.csr_wdata_i     = '0;
        bus.retire_i        = 1'b0;
        bus.trap_i          = 1'b0;
        bus.trap_cause_i    = '0;
        bus.trap_pc_i       = '0;
        bus.mret_i          = 1'b0;

        tick(); tick();
        chk("reset_mtvec", bus.mtvec_o, 32'h0);
        chk("reset_mepc",  bus.mepc_o,  32'h0);
        chk("reset_mie",   {31'h0, bus.mie_o}, 32'h0);
        rd(12'hC00, v); chk("reset_cycle", v, 32'h0);

        rst = 1'b0;
        repeat (5) tick();
        rd(12'hC00, v); chk("cycle_after_5", v, 32'd5);
        rd(12'hC80, v); chk("cycleh_after_5", v, 32'd0);
        chk("cycle_legal", {31'h0, bus.csr_illegal_o}, 32'h0);

        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00, v); chk("mcycle_loaded", v, 32'hFFFF_FFFF);
        tick();
        rd(12'hB00, v); chk("mcycle_wrap_lo", v, 32'h0);
        rd(12'hB80, v); chk("mcycle_carry_hi", v, 32'h1);

        wr(12'h305, 32'h8000_0003);
        chk("mtvec_align", bus.mtvec_o, 32'h8000_0000);
        wr(12'h341, 32'h0000_0123);
        chk("mepc_align", bus.mepc_o, 32'h0000_0120);
        wr(12'h340, 32'hDEAD_BEEF);
        rd(12'h340, v); chk("mscratch_rw", v, 32'hDEAD_BEEF);

        wr(12'h300, 32'h0000_0008);
        chk("mie_set", {31'h0, bus.mie_o}, 32'h1);

        bus.trap_i       = 1'b1;
        bus.trap_pc_i    = 32'h0000_0100;
        bus.trap_cause_i = 32'h0000_000B;
        wr(12'h341, 32'h0000_0055);
        bus.trap_i       = 1'b0;
        chk("trap_mepc", bus.mepc_o, 32'h0000_0100);
        rd(12'h342, v); chk("trap_mcause", v, 32'h0000_000B);
        chk("trap_mie", {31'h0, bus.mie_o}, 32'h0);
        rd(12'h300, v); chk("trap_mstatus", v, 32'h0000_0080);

        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;
        chk("mret_mie", {31'h0, bus.mie_o}, 32'h1);
        rd(12'h300, v); chk("mret_mstatus", v, 32'h0000_0088);

        // trap wins over mret in the same cycle
        bus.trap_i = 1'b1;
        bus.mret_i = 1'b1;
        bus.trap_pc_i = 32'h0000_0203;
        tick();
        bus.trap_i = 1'b0;
        bus.mret_i = 1'b0;
        rd(12'h300, v); chk("trap_over_mret", v, 32'h0000_0080);
        chk("trap_pc_align", bus.mepc_o, 32'h0000_0200);

        wr(12'h300, 32'hFFFF_FFFF);
        rd(12'h300, v); chk("mstatus_mask", v, 32'h0000_0088);

        bus.csr_raddr_i = 12'hC00;
        bus.csr_wr_intent_i = 1'b1;
        #1;
        chk("ro_write_intent_illegal", {31'h0, bus.csr_illegal_o}, 32'h1);
        bus.csr_wr_intent_i = 1'b0;
        #1;
        chk("ro_read_legal", {31'h0, bus.csr_illegal_o}, 32'h0);

        wr(12'hB00, 32'h0);
        wr(12'hC00, 32'h0000_1234);
        rd(12'hB00, v); chk("ro_write_dropped", v, 32'h1);

        rd(12'h7FF, v);
        chk("unimpl_illegal", {31'h0, bus.csr_illegal_o}, 32'h1);
        chk("unimpl_rdata", v, 32'h0);

        wr(12'hB02, 32'h0);
        bus.retire_i = 1'b1;
        repeat (3) tick();
        rd(12'hC02, v); chk("instret_count", v, 32'd3);
        wr(12'hB02, 32'h0000_0010);
        bus.retire_i = 1'b0;
        rd(12'hB02, v); chk("instret_load_wins", v, 32'h0000_0010);

        rst = 1'b1;
        bus.trap_i   = 1'b1;
        bus.retire_i = 1'b1;
        wr(12'h305, 32'hFFFF_FFFC);
        bus.trap_i   = 1'b0;
        bus.retire_i = 1'b0;
        chk("rst_mtvec", bus.mtvec_o, 32'h0);
        chk("rst_mepc",  bus.mepc_o,  32'h0);
        chk("rst_mie",   {31'h0, bus.mie_o}, 32'h0);
        rd(12'h340, v); chk("rst_mscratch", v, 32'h0);
        rd(12'hB02, v); chk("rst_minstret", v, 32'h0);
        rd(12'h300, v); chk("rst_mstatus", v, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the CSR data width.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 The block SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port csr_raddr_i, input, 12 bits: decode-stage read address.
REQ-005 The block SHALL have port csr_wr_intent_i, input, 1 bit: the instruction at decode will write its CSR.
REQ-006 The block SHALL have port csr_rdata_o, output, WIDTH bits: combinational read data.
REQ-007 The block SHALL have port csr_illegal_o, output, 1 bit: combinational illegal-access flag.
REQ-008 The block SHALL have port csr_we_i, input, 1 bit: writeback-stage write enable.
REQ-009 The block SHALL have port csr_waddr_i, input, 12 bits: write address.
REQ-010 The block SHALL have port csr_wdata_i, input, WIDTH bits: write data, which is the CSR ALU result.
REQ-011 The block SHALL have port retire_i, input, 1 bit: one instruction retires this cycle.
REQ-012 The block SHALL have port trap_i, input, 1 bit: trap entry this cycle.
REQ-013 The block SHALL have ports trap_cause_i and trap_pc_i, inputs, WIDTH bits each.
REQ-014 The block SHALL have port mret_i, input, 1 bit: trap return this cycle.
REQ-015 The block SHALL have ports mtvec_o and mepc_o, outputs, WIDTH bits each, and mie_o, output, 1 bit: registered state.

Function
REQ-016 The block SHALL implement these CSRs:
- mstatus 0x300: only MIE[3] and MPIE[7] are stored; all other bits read 0.
- mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
- mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82.
- Read-only aliases cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82.
REQ-017 Reads SHALL be combinational from current register state: a write in the same cycle is not visible until the next cycle, because forwarding belongs to the hazard unit.
REQ-018 csr_illegal_o SHALL be 1 when csr_raddr_i is unimplemented, or when csr_wr_intent_i=1 and csr_raddr_i[11:10]=2'b11; unimplemented reads SHALL return 0.
REQ-019 A write SHALL take effect at the clock edge; writes to read-only or unimplemented addresses SHALL be silently dropped.
REQ-020 Writes SHALL force mtvec[1:0] and mepc[1:0] to 0 (direct mode, no compressed instructions).
REQ-021 The mcycle 64-bit counter SHALL increment by 1 every cycle that reset_i=0, and wrap from 2^64-1 to 0.
REQ-022 The minstret 64-bit counter SHALL increment by 1 on retire_i=1, and wrap from 2^64-1 to 0.
REQ-023 A CSR write to either half of a counter SHALL load that half, hold the other half, and suppress that counter's increment in that cycle.
REQ-024 Trap entry (trap_i=1) SHALL, in one cycle:
- load mepc from trap_pc_i with bits [1:0] forced to 0;
- load mcause from trap_cause_i;
- set MPIE to MIE;
- clear MIE.
REQ-025 mret_i=1 SHALL set MIE to MPIE and set MPIE to 1.
REQ-026 Simultaneous events SHALL resolve by this priority:
- trap_i over mret_i;
- trap_i or mret_i over a CSR write to mstatus, mepc or mcause, which is dropped;
- writes to other CSRs proceed normally.
REQ-027 mtvec_o, mepc_o and mie_o SHALL reflect register state directly, with no extra latency.

Reset
REQ-028 When reset_i=1 at a clock edge, every CSR, both counters, MIE and MPIE SHALL be cleared to 0; mtvec_o, mepc_o and mie_o therefore read 0 in the following cycle.
REQ-029 Reset SHALL override trap_i, mret_i, csr_we_i and retire_i in the same cycle.
REQ-030 Reset asserted mid-operation SHALL take effect at the next edge, with no partial update.

Structure
REQ-031 CSR address constants and mstatus bit positions SHALL live in the shared control macros/package, alongside the CSR ALU control encodings.
REQ-032 One sub-module SHALL be used, csr_counter64, with 64-bit value, increment enable, and per-half load; it is instantiated for mcycle and minstret.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset, then 5 idle cycles -> reading 0xC00 gives 5; 0xC80 gives 0; csr_illegal_o=0.
- Write 0xB00=0xFFFFFFFF, then one idle cycle -> mcycle low reads 0 and mcycleh reads 1 (carry, wrap).
- Write 0x305=0x80000003 -> mtvec_o=0x80000000 next cycle.
- With MIE=1, assert trap_i with pc=0x100, cause=0xB, plus a simultaneous write 0x341=0x55 -> mepc_o=0x100, mcause=0xB, MIE=0, MPIE=1.
- mret_i the following cycle -> mie_o=1 and MPIE=1.
- csr_raddr_i=0xC00 with csr_wr_intent_i=1 -> csr_illegal_o=1; a write to 0xC00 leaves the counter unchanged.
- csr_raddr_i=0x7FF -> csr_illegal_o=1 and csr_rdata_o=0.
- retire_i=1 and a write 0xB02=0x10 in the same cycle -> minstret reads 0x10 next cycle.
